// File: rtl/usart_pkg.sv
// Shared types and constants for the DMA upload engine and its serial shifter.
package usart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int FRAME_BITS = 10;
  localparam int TIMER_W    = 16;

  // 8N1 frame as shifted out LSB first: start 0, D0..D7, stop 1.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/usart_dma_upload_if.sv
// DMA read port between the upload engine (master) and CPC memory (slave).
// Handshake: master holds dma_rd_o with a stable dma_adr_o until a cycle in
// which dma_ack_i is high; dma_dat_i is valid in that same cycle. An ack
// while dma_rd_o is low carries no meaning and is ignored.
interface usart_dma_upload_if;
  logic [15:0] dma_adr_o;
  logic        dma_rd_o;
  logic        dma_ack_i;
  logic [7:0]  dma_dat_i;

  modport master (
    output dma_adr_o, dma_rd_o,
    input  dma_ack_i, dma_dat_i
  );

  modport slave (
    input  dma_adr_o, dma_rd_o,
    output dma_ack_i, dma_dat_i
  );
endinterface

// File: rtl/usart_tx_shifter.sv
// 8N1 transmit shifter: 16-bit bit timer, 10-bit shift register, bit counter.
// Accepts a byte when ready_o, including in the last cycle of a stop bit.
module usart_tx_shifter
  import usart_pkg::*;
#(
  parameter int DIVISOR = 103
) (
  input  logic       busclk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       idle_o,
  output logic       tx_o
);

  localparam logic [TIMER_W-1:0] RELOAD   = TIMER_W'(DIVISOR);
  localparam logic [3:0]         LAST_BIT = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  active_q, active_d;
  logic                  bit_end;

  assign bit_end = active_q && (timer_q == '0);
  // Ready in the final stop-bit cycle so a buffered byte follows gaplessly.
  assign ready_o = !active_q || (bit_end && (bit_cnt_q == LAST_BIT));
  assign idle_o  = !active_q;
  assign tx_o    = active_q ? shreg_q[0] : 1'b1;

  always_comb begin
    shreg_d   = shreg_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    active_d  = active_q;
    if (load_i && ready_o) begin
      shreg_d   = frame_word(data_i);
      timer_d   = RELOAD;
      bit_cnt_d = '0;
      active_d  = 1'b1;
    end else if (bit_end) begin
      if (bit_cnt_q == LAST_BIT) begin
        active_d = 1'b0;
      end else begin
        shreg_d   = {1'b1, shreg_q[FRAME_BITS-1:1]};
        timer_d   = RELOAD;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (active_q) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge busclk_i) begin
    if (reset_i) begin
      shreg_q   <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      active_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/usart_dma_upload.sv
// Memory-to-serial upload engine: fetch FSM + one-byte prefetch feeding an 8N1 shifter.
// Optional trailing mod-256 checksum frame when USART_DMA_UPLOAD_CHECKSUM_EN is defined.
module usart_dma_upload
  import usart_pkg::*;
#(
  parameter int DIVISOR = 103
) (
  input  logic                busclk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [15:0]         adr_i,
  input  logic [15:0]         len_i,
  usart_dma_upload_if.master  dma,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o,
  output fetch_state_e        state_o
);

  fetch_state_e state_q, state_d;
  logic [15:0]  adr_q, adr_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         sh_ready, sh_idle, sh_load;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
  logic [7:0]   sum_q, sum_d;
  logic         ck_pend_q, ck_pend_d;
`endif

  assign sh_load       = buf_valid_q && sh_ready;
  assign dma.dma_rd_o  = (state_q == REQ);
  assign dma.dma_adr_o = adr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign state_o       = state_q;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
    sum_d       = sum_q;
    ck_pend_d   = ck_pend_q;
`endif
    if (sh_load) buf_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          busy_d = 1'b1;
          cnt_d  = len_i;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
          sum_d     = '0;
          ck_pend_d = 1'b1;
`endif
          if (len_i != '0) begin
            adr_d   = adr_i;
            state_d = REQ;
          end else begin
            state_d = WAIT;
          end
        end
      end
      REQ: begin
        if (dma.dma_ack_i) begin
          buf_d       = dma.dma_dat_i;
          buf_valid_d = 1'b1;
          adr_d       = adr_q + 16'd1;
          cnt_d       = cnt_q - 16'd1;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
          sum_d       = sum_q + dma.dma_dat_i;
`endif
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          if (!buf_valid_q) state_d = REQ;
        end else if (!buf_valid_q) begin
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
          // Checksum rides through the prefetch buffer like a data byte.
          if (ck_pend_q) begin
            buf_d       = sum_q;
            buf_valid_d = 1'b1;
            ck_pend_d   = 1'b0;
          end else if (sh_idle) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          if (sh_idle) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge busclk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
      sum_q       <= '0;
      ck_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef USART_DMA_UPLOAD_CHECKSUM_EN
      sum_q       <= sum_d;
      ck_pend_q   <= ck_pend_d;
`endif
    end
  end

  usart_tx_shifter #(.DIVISOR(DIVISOR)) u_shifter (
    .busclk_i (busclk_i),
    .reset_i  (reset_i),
    .load_i   (sh_load),
    .data_i   (buf_q),
    .ready_o  (sh_ready),
    .idle_o   (sh_idle),
    .tx_o     (tx_o)
  );

endmodule
